// File: rtl/axi_rd_slave_mem_pkg.sv
// Shared AXI encodings and read-side FSM state type for the TPU harness slaves.
// The write-side slave imports the same package.
package tpu_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axi_rd_slave_mem_if.sv
// AXI4 read address / read data channel bundle.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where VALID and READY are both high; once VALID is raised the source holds
// VALID and the whole payload stable until that edge.
interface axi_rd_slave_mem_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  import tpu_axi_pkg::*;

  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [3:0]        ARREGION;
  logic              ARVALID;
  logic              ARREADY;

  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axi_rd_slave_mem.sv
// AXI4 read-only slave memory: one burst at a time, fixed read latency,
// beat-by-beat streaming with back-pressure, plus a backdoor preload port.
module axi_rd_slave_mem
  import tpu_axi_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int MEM_DEPTH = 1024,
  parameter int RD_LAT    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_rd_slave_mem_if.slave            axi,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr,
  input  logic [DATA_W-1:0]            bd_wdata,
  output logic                         busy,
  output rd_state_e                    dbg_state
);

  localparam int AW       = $clog2(MEM_DEPTH);
  localparam int SIZE_LOG = $clog2(DATA_W / 8);
  localparam logic [3:0] LAT_LAST = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  rd_state_e         state_q, state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        len_q, len_d;
  logic              fixed_q, fixed_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic              busy_q, busy_d;

  logic              ar_hs;
  logic              r_hs;
  logic [ADDR_W-1:0] ar_word;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_idx;
  logic [7:0]        ld_cnt;
  logic              unused_ok;

  assign ar_hs     = axi.ARVALID & arready_q;
  assign r_hs      = rvalid_q & axi.RREADY;
  assign ar_word   = axi.ARADDR >> SIZE_LOG;
  assign unused_ok = ^axi.ARREGION;

  // Backdoor preload; deliberately has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
  end

  // Next-state logic: FSM transitions, burst bookkeeping and beat loading.
  always_comb begin
    state_d    = state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rid_d      = rid_q;
    id_d       = id_q;
    len_d      = len_q;
    fixed_d    = fixed_q;
    err_d      = err_q;
    idx_d      = idx_q;
    beat_cnt_d = beat_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    ld_en      = 1'b0;
    ld_idx     = idx_q;
    ld_cnt     = beat_cnt_q;

    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d  = 1'b0;
          id_d       = axi.ARID;
          len_d      = axi.ARLEN;
          fixed_d    = (axi.ARBURST == BURST_FIXED);
          err_d      = (axi.ARSIZE != 3'(SIZE_LOG)) |
                       (axi.ARBURST == BURST_WRAP) | (axi.ARBURST == 2'd3);
          idx_d      = ar_word;
          beat_cnt_d = 8'd0;
          lat_cnt_d  = 4'd0;
          if (RD_LAT == 0) begin
            state_d = BURST;
            ld_en   = 1'b1;
            ld_idx  = ar_word;
            ld_cnt  = 8'd0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        arready_d = 1'b0;
        if (lat_cnt_q == LAT_LAST) begin
          state_d = BURST;
          ld_en   = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      BURST: begin
        if (r_hs) begin
          if (rlast_q) begin
            state_d   = IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            ld_en      = 1'b1;
            ld_idx     = fixed_q ? idx_q : idx_q + ADDR_W'(1);
            ld_cnt     = beat_cnt_q + 8'd1;
            idx_d      = ld_idx;
            beat_cnt_d = ld_cnt;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Beat load: the array is read before this edge's backdoor write lands,
    // so a colliding write is seen only by later beats.
    if (ld_en) begin
      rvalid_d = 1'b1;
      rid_d    = id_d;
      rlast_d  = (ld_cnt == len_d);
      if (err_d) begin
        rresp_d = RESP_SLVERR;
        rdata_d = '0;
      end else if (ld_idx >= ADDR_W'(MEM_DEPTH)) begin
        rresp_d = RESP_DECERR;
        rdata_d = '0;
      end else begin
        rresp_d = RESP_OKAY;
        rdata_d = mem[ld_idx[AW-1:0]];
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; async reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rid_q      <= '0;
      id_q       <= '0;
      len_q      <= 8'd0;
      fixed_q    <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      beat_cnt_q <= 8'd0;
      lat_cnt_q  <= 4'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rid_q      <= rid_d;
      id_q       <= id_d;
      len_q      <= len_d;
      fixed_q    <= fixed_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      beat_cnt_q <= beat_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign axi.ARREADY = arready_q;
  assign axi.RVALID  = rvalid_q;
  assign axi.RLAST   = rlast_q;
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = rresp_q;
  assign axi.RID     = rid_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_axi_rd_slave_mem.sv
// Bench for axi_rd_slave_mem: reference memory model, expected-beat queue,
// independent R-channel monitor.
`timescale 1ns/1ps
module tb_axi_rd_slave_mem;
  import tpu_axi_pkg::*;

  localparam int ID_W      = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 128;
  localparam int MEM_DEPTH = 1024;
  localparam int RD_LAT    = 2;
  localparam int AW        = $clog2(MEM_DEPTH);
  localparam int EXP_W     = ID_W + 2 + 1 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  axi_rd_slave_mem_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();
  logic              bd_we = 1'b0;
  logic [AW-1:0]     bd_addr = '0;
  logic [DATA_W-1:0] bd_wdata = '0;
  logic              busy;
  rd_state_e         dbg_state;

  axi_rd_slave_mem #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MEM_DEPTH(MEM_DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .axi(axi),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] mem_m [MEM_DEPTH];
  int hs_cyc      = 0;
  int beats_seen  = 0;
  int rready_mode = 0;
  int rr_phase    = 0;

  task automatic check(input string name, input logic [EXP_W-1:0] act,
                       input logic [EXP_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: beats of a burst straight from the AXI rules.
  task automatic push_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
    longint unsigned start;
    longint unsigned w;
    logic [1:0]        resp;
    logic [DATA_W-1:0] d;
    start = longint'(addr) / (DATA_W / 8);
    for (int i = 0; i <= int'(len); i++) begin
      w = (burst == 2'd0) ? start : start + longint'(i);
      if (size != 3'd4 || burst == 2'd2 || burst == 2'd3) begin
        resp = 2'd2; d = '0;
      end else if (w >= MEM_DEPTH) begin
        resp = 2'd3; d = '0;
      end else begin
        resp = 2'd0; d = mem_m[w];
      end
      exp_q.push_back({id, resp, (i == int'(len)), d});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bd_write(input int a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = AW'(a); bd_wdata = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic ar_send(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    bit ok;
    ok = 1'b0;
    push_burst(id, addr, len, size, burst);
    @(posedge clk); #1;
    axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = len; axi.ARSIZE = size;
    axi.ARBURST = burst; axi.ARREGION = 4'($urandom); axi.ARVALID = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (axi.ARREADY) begin ok = 1'b1; hs_cyc = cyc; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL ar_handshake_timeout: ARREADY never high");
      exp_q.delete();
    end
    @(posedge clk); #1;
    axi.ARVALID = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL burst_timeout: %0d beats still expected, busy=%0b", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  // RREADY generator: 0 always ready, 1 pattern 1,0,0,..., 2 random.
  initial begin
    axi.RREADY = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rready_mode)
        0: axi.RREADY = 1'b1;
        1: begin axi.RREADY = (rr_phase % 3 == 0); rr_phase++; end
        default: axi.RREADY = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic             prev_rvalid = 1'b0;
  logic             stalled     = 1'b0;
  logic             after_last  = 1'b0;
  logic [EXP_W-1:0] held;
  logic [EXP_W-1:0] cur;
  logic [EXP_W-1:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_rvalid = 1'b0; stalled = 1'b0; after_last = 1'b0;
    end else begin
      cur = {axi.RID, axi.RRESP, axi.RLAST, axi.RDATA};
      if (after_last) begin
        check("arready_after_last", EXP_W'(axi.ARREADY), EXP_W'(1));
        check("rvalid_after_last", EXP_W'(axi.RVALID), EXP_W'(0));
        after_last = 1'b0;
      end
      if (axi.RVALID && !prev_rvalid)
        check("first_beat_latency", EXP_W'(cyc), EXP_W'(hs_cyc + 1 + RD_LAT));
      if (stalled && axi.RVALID)
        check("stall_stable", cur, held);
      if (axi.RVALID && axi.RREADY) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_beat: got %0h with nothing expected", cur);
        end else begin
          e = exp_q.pop_front();
          check("rdata", EXP_W'(axi.RDATA), EXP_W'(e[DATA_W-1:0]));
          check("rlast", EXP_W'(axi.RLAST), EXP_W'(e[DATA_W]));
          check("rresp", EXP_W'(axi.RRESP), EXP_W'(e[DATA_W+2:DATA_W+1]));
          check("rid", EXP_W'(axi.RID), EXP_W'(e[EXP_W-1:DATA_W+3]));
          check("busy_in_burst", EXP_W'(busy), EXP_W'(1));
          if (axi.RLAST) after_last = 1'b1;
        end
        stalled = 1'b0;
      end else if (axi.RVALID) begin
        stalled = 1'b1;
        held = cur;
      end else begin
        stalled = 1'b0;
      end
      prev_rvalid = axi.RVALID;
    end
  end

  // ---------------- stimulus ----------------
  int base;
  int w0;
  bit ok_r;

  initial begin
    axi.ARVALID = 1'b0; axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0;
    axi.ARSIZE = '0; axi.ARBURST = '0; axi.ARREGION = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_arready", EXP_W'(axi.ARREADY), EXP_W'(0));
    check("reset_rvalid", EXP_W'(axi.RVALID), EXP_W'(0));
    check("reset_rlast", EXP_W'(axi.RLAST), EXP_W'(0));
    check("reset_rdata", EXP_W'(axi.RDATA), EXP_W'(0));
    check("reset_rresp", EXP_W'(axi.RRESP), EXP_W'(0));
    check("reset_rid", EXP_W'(axi.RID), EXP_W'(0));
    check("reset_busy", EXP_W'(busy), EXP_W'(0));
    check("reset_state", EXP_W'(dbg_state), EXP_W'(IDLE));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("idle_arready", EXP_W'(axi.ARREADY), EXP_W'(1));

    for (int i = 0; i < MEM_DEPTH; i++) bd_write(i, rand_word());
    for (int i = 0; i < 4; i++) bd_write(i, DATA_W'(32'hA0 + i));

    // Basic 4-beat INCR burst, always ready.
    rready_mode = 0;
    ar_send(4'h5, 32'h0, 8'd3, 3'd4, BURST_INCR);
    wait_done();

    // Same burst under back-pressure.
    rready_mode = 1; rr_phase = 0;
    base = beats_seen;
    ar_send(4'h9, 32'h0, 8'd3, 3'd4, BURST_INCR);
    wait_done();
    check("toggle_handshakes", EXP_W'(beats_seen - base), EXP_W'(4));

    // FIXED burst on word 2.
    rready_mode = 0;
    ar_send(4'h3, 32'h20, 8'd2, 3'd4, BURST_FIXED);
    wait_done();

    // INCR running off the end of the array.
    ar_send(4'h7, ADDR_W'((MEM_DEPTH - 2) * 16), 8'd3, 3'd4, BURST_INCR);
    wait_done();

    // Size mismatch, WRAP and reserved burst types.
    ar_send(4'h1, 32'h0, 8'd1, 3'd2, BURST_INCR);
    wait_done();
    ar_send(4'h2, 32'h40, 8'd3, 3'd4, BURST_WRAP);
    wait_done();
    ar_send(4'h4, 32'h40, 8'd1, 3'd4, 2'd3);
    wait_done();

    // Longest burst.
    rready_mode = 2;
    ar_send(4'hC, ADDR_W'(100 * 16), 8'd255, 3'd4, BURST_INCR);
    wait_done();

    // Random bursts with idle-time backdoor updates.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) bd_write($urandom_range(0, MEM_DEPTH - 1), rand_word());
      w0 = ($urandom_range(0, 3) == 0) ? $urandom_range(MEM_DEPTH - 8, MEM_DEPTH + 4)
                                      : $urandom_range(0, MEM_DEPTH - 1);
      ar_send(ID_W'($urandom), ADDR_W'(w0 * 16 + $urandom_range(0, 15)),
              8'($urandom_range(0, 15)),
              ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd4,
              ($urandom_range(0, 4) == 0) ? 2'($urandom) : BURST_INCR);
      wait_done();
    end

    // Reset in the middle of an 8-beat burst.
    rready_mode = 0;
    for (int i = 0; i < 8; i++) bd_write(i, rand_word());
    base = beats_seen;
    ar_send(4'hE, 32'h0, 8'd7, 3'd4, BURST_INCR);
    ok_r = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (beats_seen >= base + 2) begin ok_r = 1'b1; break; end
    end
    if (!ok_r) begin
      n_checks++; n_fail++;
      $display("FAIL midburst_wait: only %0d beats seen", beats_seen - base);
    end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("rst_rvalid_drop", EXP_W'(axi.RVALID), EXP_W'(0));
    check("rst_arready_drop", EXP_W'(axi.ARREADY), EXP_W'(0));
    check("rst_busy_drop", EXP_W'(busy), EXP_W'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ar_send(4'hB, 32'h0, 8'd7, 3'd4, BURST_INCR);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
